// File: rtl/serial_or_accumulator_pkg.sv
// Shared types and helpers for the serial OR accumulator.
package serial_or_pkg;

   // IDLE: no beat of the current packet yet; ACCUM: at least one beat,
   // no last yet; HOLD: completed result presented downstream.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Width of a beat counter that must be able to hold the value max.
   function automatic int beat_cnt_w(input int max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/serial_or_accumulator_or_word.sv
// Bitwise OR of two words built entirely from 2:1 mux primitives.
// Each bit: sel = a[i], d0 = b[i], d1 = 1 -> a[i] | b[i].

// Single-bit 2:1 mux primitive.
module or_mux2 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);
   assign y = sel ? d1 : d0;
endmodule

// WIDTH-bit OR word from WIDTH mux instances.
module or_word_using_mux #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] o
);
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      or_mux2 u_mux (
         .d0  (b[gi]),
         .d1  (1'b1),
         .sel (a[gi]),
         .y   (o[gi])
      );
   end
endmodule

// File: rtl/serial_or_accumulator.sv
// Streaming stage: ORs the beats of a valid/ready packet and emits one
// result (OR word, saturating beat count, overflow flag) per packet.
// Optional build macro: SERIAL_OR_ACC_PIPE_EN -- when defined, a beat may
// be accepted in the same cycle the held result is taken, giving
// zero-bubble back-to-back packets. Undefined: one idle cycle between packets.
module serial_or_accumulator
   import serial_or_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                up_valid,
   output logic                                up_ready,
   input  logic [WIDTH-1:0]                    up_data,
   input  logic                                up_last,
   output logic                                down_valid,
   input  logic                                down_ready,
   output logic [WIDTH-1:0]                    down_data,
   output logic [beat_cnt_w(MAX_BEATS)-1:0]    down_beats,
   output logic                                down_ovf
);

   localparam int CW = beat_cnt_w(MAX_BEATS);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg;
   logic [CW-1:0]    cnt_reg;
   logic             ovf_reg;
   logic [WIDTH-1:0] down_data_reg;
   logic [CW-1:0]    down_beats_reg;
   logic             down_ovf_reg;

   logic             beat;
   logic             take;
   logic [WIDTH-1:0] acc_base;
   logic [CW-1:0]    cnt_base;
   logic             ovf_base;
   logic [WIDTH-1:0] or_word;
   logic [CW-1:0]    cnt_inc;
   logic             ovf_new;

   assign beat = up_valid & up_ready;
   assign take = (state_reg == HOLD) & down_ready;

   // A beat taken while in HOLD (pipelined build only) opens a fresh packet,
   // so the accumulators it builds on are treated as already cleared.
   assign acc_base = (state_reg == HOLD) ? '0   : acc_reg;
   assign cnt_base = (state_reg == HOLD) ? '0   : cnt_reg;
   assign ovf_base = (state_reg == HOLD) ? 1'b0 : ovf_reg;

   or_word_using_mux #(.WIDTH(WIDTH)) u_or (
      .a (acc_base),
      .b (up_data),
      .o (or_word)
   );

   // Count saturates at MAX_BEATS; a beat arriving at saturation flags overflow.
   assign cnt_inc = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 1'b1;
   assign ovf_new = ovf_base | (cnt_base == CNT_MAX);

   // Next-state and handshake decode.
   always_comb begin
      state_next = state_reg;
      up_ready   = 1'b0;
      case (state_reg)
         IDLE, ACCUM: begin
            up_ready = 1'b1;
            if (up_valid)
               state_next = up_last ? HOLD : ACCUM;
         end
         HOLD: begin
`ifdef SERIAL_OR_ACC_PIPE_EN
            up_ready = down_ready;
`endif
            if (down_ready) begin
               state_next = IDLE;
`ifdef SERIAL_OR_ACC_PIPE_EN
               if (up_valid)
                  state_next = up_last ? HOLD : ACCUM;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Accumulators and result registers; a beat in the take cycle overrides the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg        <= '0;
         cnt_reg        <= '0;
         ovf_reg        <= 1'b0;
         down_data_reg  <= '0;
         down_beats_reg <= '0;
         down_ovf_reg   <= 1'b0;
      end else begin
         if (take) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            ovf_reg        <= 1'b0;
            down_data_reg  <= '0;
            down_beats_reg <= '0;
            down_ovf_reg   <= 1'b0;
         end
         if (beat) begin
            acc_reg <= or_word;
            cnt_reg <= cnt_inc;
            ovf_reg <= ovf_new;
            if (up_last) begin
               down_data_reg  <= or_word;
               down_beats_reg <= cnt_inc;
               down_ovf_reg   <= ovf_new;
            end
         end
      end
   end

   assign down_valid = (state_reg == HOLD);
   assign down_data  = down_data_reg;
   assign down_beats = down_beats_reg;
   assign down_ovf   = down_ovf_reg;

endmodule

// File: tb/tb_serial_or_accumulator.sv
// Directed-vector bench for serial_or_accumulator; honours SERIAL_OR_ACC_PIPE_EN.
module tb_serial_or_accumulator;

   localparam int WIDTH = 8;
   localparam int MAX_BEATS = 16;
   localparam int CW = $clog2(MAX_BEATS + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             up_valid = 1'b0;
   logic             up_ready;
   logic [WIDTH-1:0] up_data = '0;
   logic             up_last = 1'b0;
   logic             down_valid;
   logic             down_ready = 1'b0;
   logic [WIDTH-1:0] down_data;
   logic [CW-1:0]    down_beats;
   logic             down_ovf;

   int vectors = 0;
   int miscompares = 0;

   serial_or_accumulator #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_last    (up_last),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_beats (down_beats),
      .down_ovf   (down_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Called at a negedge; offers one beat, waits (bounded) for acceptance,
   // returns at the negedge after the accepting posedge.
   task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
      int waited = 0;
      up_valid = 1'b1;
      up_data  = d;
      up_last  = last;
      while (!up_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!up_ready) check("up_ready_wait", 32'(up_ready), 32'd1);
      @(negedge clk);
      up_valid = 1'b0;
      up_last  = 1'b0;
   endtask

   // Called at a negedge with a result expected; checks and consumes it.
   task automatic take_result(input string tag, input logic [WIDTH-1:0] d,
                              input int beats, input logic ovf);
      check({tag, "_valid"}, 32'(down_valid), 32'd1);
      check({tag, "_data"},  32'(down_data),  32'(d));
      check({tag, "_beats"}, 32'(down_beats), 32'(beats));
      check({tag, "_ovf"},   32'(down_ovf),   32'(ovf));
      down_ready = 1'b1;
      @(negedge clk);
      down_ready = 1'b0;
      check({tag, "_idle_valid"}, 32'(down_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(up_ready),   32'd1);
   endtask

   initial begin
      // Reset for two cycles with traffic present.
      up_valid = 1'b1; up_data = 8'hAA; up_last = 1'b1; down_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_up_ready",   32'(up_ready),   32'd1);
      check("rst_down_valid", 32'(down_valid), 32'd0);
      check("rst_down_data",  32'(down_data),  32'd0);
      check("rst_down_beats", 32'(down_beats), 32'd0);
      check("rst_down_ovf",   32'(down_ovf),   32'd0);
      rst = 1'b0; up_valid = 1'b0; up_last = 1'b0; down_ready = 1'b0; up_data = '0;
      @(negedge clk);

      // Three-beat packet; result valid the cycle after the last beat.
      send_beat(8'h01, 1'b0);
      send_beat(8'h10, 1'b0);
      check("p3_not_valid_early", 32'(down_valid), 32'd0);
      send_beat(8'h80, 1'b1);
      take_result("p3", 8'h91, 3, 1'b0);

      // Single zero beat with last goes straight to HOLD.
      send_beat(8'h00, 1'b1);
      take_result("single", 8'h00, 1, 1'b0);

      // Overflow: 18 beats, each a single rotating bit.
      for (int i = 0; i < 18; i++) begin
         logic [WIDTH-1:0] one;
         one = 8'h01;
         send_beat(one << (i % 8), (i == 17));
      end
      take_result("ovf", 8'hFF, 16, 1'b1);

      // Exactly MAX_BEATS beats: saturated count, no overflow.
      for (int i = 0; i < 16; i++) send_beat(8'h02, (i == 15));
      take_result("max", 8'h02, 16, 1'b0);

      // Backpressure: hold five cycles while a beat is offered.
      send_beat(8'h3C, 1'b0);
      send_beat(8'h42, 1'b1);
      up_valid = 1'b1; up_data = 8'h21; up_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",    32'(down_valid), 32'd1);
         check("bp_data",     32'(down_data),  32'h7E);
         check("bp_beats",    32'(down_beats), 32'd2);
         check("bp_up_ready", 32'(up_ready),   32'd0);
         @(negedge clk);
      end
      down_ready = 1'b1;
`ifdef SERIAL_OR_ACC_PIPE_EN
      check("bp_release_up_ready", 32'(up_ready), 32'd1);
      @(negedge clk);
      down_ready = 1'b0; up_valid = 1'b0; up_last = 1'b0;
      take_result("pipe", 8'h21, 1, 1'b0);
`else
      up_valid = 1'b0; up_last = 1'b0;
      @(negedge clk);
      down_ready = 1'b0;
      check("bp_release_valid",    32'(down_valid), 32'd0);
      check("bp_release_up_ready", 32'(up_ready),   32'd1);
`endif

      // Reset mid-packet after two beats, then a fresh single-beat packet.
      send_beat(8'hF0, 1'b0);
      send_beat(8'h0F, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_beat(8'h04, 1'b1);
      take_result("abort", 8'h04, 1, 1'b0);

      // Reset while a result is held discards it.
      send_beat(8'h55, 1'b1);
      check("hold_before_rst", 32'(down_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("hold_rst_valid", 32'(down_valid), 32'd0);
      check("hold_rst_data",  32'(down_data),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
